// File: rtl/mmio_uart_hub_pkg.sv
// Shared definitions for the MMIO UART hub: register offsets inside a
// channel's 4-byte window, STATUS bit positions, TX FSM state encoding and
// the TX busy-handshake timeout.
package mmio_uart_pkg;

  // Byte offsets within a channel window
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_TXDATA  = 2'd1;
  localparam logic [1:0] REG_RXDATA  = 2'd2;
  localparam logic [1:0] REG_RXCOUNT = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_FULL     = 1;
  localparam int unsigned ST_TX_ACTIVE   = 2;
  localparam int unsigned ST_RX_OVERRUN  = 3;
  localparam int unsigned ST_TX_OVERRUN  = 4;
  localparam int unsigned ST_IRQ_EN      = 5;

  // Cycles the TX FSM waits for tx_busy to rise after a load
  localparam int unsigned TX_TIMEOUT = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_hub_if.sv
// Core-side MMIO bus of the UART hub.
//   vaddr  : byte address          data  : write data ([7:0] used)
//   memWE  : one-cycle write strobe memRE : one-cycle read strobe
//   sel    : combinational address hit (slave -> master)
//   q      : registered read data    (slave -> master)
interface mmio_uart_hub_if;
  logic [31:0] vaddr;
  logic [31:0] data;
  logic        memWE;
  logic        memRE;
  logic        sel;
  logic [31:0] q;

  modport master (output vaddr, data, memWE, memRE, input sel, q);
  modport slave  (input vaddr, data, memWE, memRE, output sel, q);
endinterface

// File: rtl/mmio_uart_hub_sync_fifo.sv
// Synchronous FIFO with a combinational head and occupancy output.
//   clock  : system clock          rst_n : synchronous active-low reset
//   push   : write wdata           pop   : drop the head entry
//   head   : oldest entry          count : occupancy 0..DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
// Pointers carry one extra MSB so full and empty differ by that bit alone.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mmio_uart_hub.sv
// MMIO hub for NCH byte UART channels. Each channel exposes a 4-byte
// register window (STATUS, TXDATA, RXDATA, RXCOUNT) starting at
// BASE_ADDR + 4*c, buffers TX and RX bytes in FIFOs and hands TX bytes to
// the transmitter through a load/busy handshake FSM.
// Ports:
//   clock, RST      : system clock, synchronous active-low reset
//   bus             : MMIO slave (vaddr/data/memWE/memRE in, sel/q out)
//   tx_byte, tx_we  : per-channel byte and one-cycle load pulse
//   tx_busy         : per-channel transmitter shifting
//   rx_byte, rx_fin : per-channel received byte and async done level
//   irq             : interrupt request
// Optional feature: define MMIO_UART_HUB_IRQ_EN for a registered irq and a
// writable STATUS[5]; otherwise irq is tied low and STATUS[5] reads 0.
module mmio_uart_hub
  import mmio_uart_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h200
) (
  input  logic              clock,
  input  logic              RST,
  mmio_uart_hub_if.slave    bus,
  output logic [NCH*8-1:0]  tx_byte,
  output logic [NCH-1:0]    tx_we,
  input  logic [NCH-1:0]    tx_busy,
  input  logic [NCH*8-1:0]  rx_byte,
  input  logic [NCH-1:0]    rx_fin,
  output logic              irq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] off;
  logic [1:0]  ch;
  logic [1:0]  roff;
  logic [31:0] rd_val;
  logic        wr_hit;
  logic        rd_hit;
  logic        unused_bits;

  logic [7:0]    status_v [NCH];
  logic [7:0]    rx_head  [NCH];
  logic [CW-1:0] rx_cnt   [NCH];
  logic [NCH-1:0] rx_empty;
  logic [NCH-1:0] irq_src;

  assign bus.sel = (bus.vaddr >= BASE_ADDR) &&
                   (bus.vaddr <  BASE_ADDR + 32'(4 * NCH));
  assign off     = bus.vaddr - BASE_ADDR;
  assign ch      = off[3:2];
  assign roff    = off[1:0];
  assign wr_hit  = bus.memWE && bus.sel;
  assign rd_hit  = bus.memRE && bus.sel;
  assign unused_bits = &{1'b0, off[31:4], bus.data[31:8]};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [1:0] CI = 2'(c);

    logic          hit_wr;
    logic          hit_rd;
    logic          tx_push;
    logic          tx_pop;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_cnt;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_full;
    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_ovr;
    logic          tx_ovr;
    logic          irq_en;
    logic          tx_active;
    logic [7:0]    st;
    tx_state_t     state, state_next;
    logic [4:0]    timer;
    logic [7:0]    byte_r;
    logic          load;

    assign hit_wr  = wr_hit && (ch == CI);
    assign hit_rd  = rd_hit && (ch == CI);
    assign tx_push = hit_wr && (roff == REG_TXDATA);
    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt[c] == CW'(FIFO_DEPTH));
    assign rx_empty[c] = (rx_cnt[c] == '0);
    assign rx_pop  = hit_rd && (roff == REG_RXDATA) && !rx_empty[c];
    // Rising edge of the synchronised receive-done level
    assign rx_push = rx_s2 && !rx_s3;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock (clock),
      .rst_n (RST),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (bus.data[7:0]),
      .head  (tx_head),
      .count (tx_cnt)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock (clock),
      .rst_n (RST),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_byte[c*8 +: 8]),
      .head  (rx_head[c]),
      .count (rx_cnt[c])
    );

    always_ff @(posedge clock) begin
      if (!RST) begin
        rx_s1  <= 1'b0;
        rx_s2  <= 1'b0;
        rx_s3  <= 1'b0;
        rx_ovr <= 1'b0;
        tx_ovr <= 1'b0;
      end else begin
        rx_s1 <= rx_fin[c];
        rx_s2 <= rx_s1;
        rx_s3 <= rx_s2;
        // A set in the same cycle as a W1C clear wins
        rx_ovr <= (rx_push && rx_full && !rx_pop) ||
                  (rx_ovr && !(hit_wr && roff == REG_STATUS &&
                               bus.data[ST_RX_OVERRUN]));
        tx_ovr <= (tx_push && tx_full && !tx_pop) ||
                  (tx_ovr && !(hit_wr && roff == REG_STATUS &&
                               bus.data[ST_TX_OVERRUN]));
      end
    end

`ifdef MMIO_UART_HUB_IRQ_EN
    always_ff @(posedge clock) begin
      if (!RST)
        irq_en <= 1'b0;
      else if (hit_wr && roff == REG_STATUS)
        irq_en <= bus.data[ST_IRQ_EN];
    end
`else
    assign irq_en = 1'b0;
`endif

    assign irq_src[c] = irq_en && (!rx_empty[c] || rx_ovr || tx_ovr);

    // TX handshake FSM
    always_ff @(posedge clock) begin
      if (!RST) begin
        state  <= TX_IDLE;
        timer  <= '0;
        byte_r <= '0;
      end else begin
        state <= state_next;
        if (state == TX_IDLE && state_next == TX_LOAD) byte_r <= tx_head;
        if (state == TX_WAIT_BUSY) timer <= timer + 5'd1;
        else                       timer <= '0;
      end
    end

    always_comb begin
      state_next = state;
      tx_pop     = 1'b0;
      load       = 1'b0;
      case (state)
        TX_IDLE:      if (!tx_empty) state_next = TX_LOAD;
        TX_LOAD: begin
          load       = 1'b1;
          tx_pop     = 1'b1;
          state_next = TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          if (tx_busy[c])                       state_next = TX_WAIT_DONE;
          else if (timer == 5'(TX_TIMEOUT - 1)) state_next = TX_IDLE;
        end
        TX_WAIT_DONE: if (!tx_busy[c]) state_next = TX_IDLE;
        default:      state_next = TX_IDLE;
      endcase
    end

    assign tx_we[c]           = load;
    assign tx_byte[c*8 +: 8]  = byte_r;
    assign tx_active          = (state != TX_IDLE) || !tx_empty;

    always_comb begin
      st                 = '0;
      st[ST_RX_NONEMPTY] = !rx_empty[c];
      st[ST_TX_FULL]     = tx_full;
      st[ST_TX_ACTIVE]   = tx_active;
      st[ST_RX_OVERRUN]  = rx_ovr;
      st[ST_TX_OVERRUN]  = tx_ovr;
      st[ST_IRQ_EN]      = irq_en;
    end
    assign status_v[c] = st;
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch == 2'(i)) begin
        case (roff)
          REG_STATUS:  rd_val = {24'b0, status_v[i]};
          REG_RXDATA:  rd_val = rx_empty[i] ? '0 : {24'b0, rx_head[i]};
          REG_RXCOUNT: rd_val = 32'(rx_cnt[i]);
          default:     rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!RST)        bus.q <= '0;
    else if (rd_hit) bus.q <= rd_val;
  end

`ifdef MMIO_UART_HUB_IRQ_EN
  always_ff @(posedge clock) begin
    if (!RST) irq <= 1'b0;
    else      irq <= |irq_src;
  end
`else
  logic unused_irq_src;
  assign unused_irq_src = |irq_src;
  assign irq = 1'b0;
`endif

endmodule
